// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encodings, round constants and GF(2^8) helpers
// used by the iterative decryptor and its S-boxes.
package aes_pkg;

    localparam int NR = 10;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXPAND  = 2'd1;
    localparam logic [1:0] DECRYPT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_mul2(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox_f(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_128_dec_iter_inv_round.sv
// One combinational inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] st_out
);
    logic [7:0]   sr_s [16];
    logic [7:0]   sb_s [16];
    logic [127:0] ark_s;
    logic [127:0] imc_s;

    // InvShiftRows: row r of column c comes from column (c - r) mod 4.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[4*c + r] = st_in[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (.a(sr_s[i]), .s(sb_s[i]));
    end

    // AddRoundKey followed by InvMixColumns on each column.
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        ark_s = 128'h0;
        imc_s = 128'h0;
        for (int i = 0; i < 16; i++) begin
            ark_s[127 - 8*i -: 8] = sb_s[i] ^ rk[127 - 8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = ark_s[127 - 32*c -: 8];
            a1 = ark_s[119 - 32*c -: 8];
            a2 = ark_s[111 - 32*c -: 8];
            a3 = ark_s[103 - 32*c -: 8];
            imc_s[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            imc_s[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            imc_s[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            imc_s[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        if (last) begin
            st_out = ark_s;
        end else begin
            st_out = imc_s;
        end
    end
endmodule

// File: rtl/aes_sbox.sv
// Forward and inverse AES S-boxes, computed from the field inverse plus affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    assign s = sbox_f(a);
endmodule

module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    assign s = inv_sbox_f(a);
endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then ten inverse
// rounds regenerating the earlier round keys, with an optional rk10 cache.
module aes_128_dec_iter
    import aes_pkg::*;
#(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out
);
    logic [1:0]   fsm_r;
    logic [3:0]   rnd_r;
    logic [127:0] st_r;
    logic [127:0] rk_r;
    logic [127:0] k0_r;
    logic [127:0] out_r;
    logic         out_valid_r;
    logic [127:0] k0_cache_r;
    logic [127:0] rk10_cache_r;
    logic         cache_valid_r;

    logic [31:0]  w0_s, w1_s, w2_s, w3_s;
    logic [31:0]  sub_in_s, sub_out_s, t_s;
    logic [7:0]   rcon_s;
    logic [127:0] next_key_s, prev_key_s, round_out_s;
    logic         cache_hit_s;

    assign {w0_s, w1_s, w2_s, w3_s} = rk_r;

    // The four key-schedule S-boxes serve next_key in EXPAND and prev_key in DECRYPT.
    always_comb begin
        if (fsm_r == DECRYPT) begin
            sub_in_s = {w3_s[23:0] ^ w2_s[23:0], w3_s[31:24] ^ w2_s[31:24]};
            rcon_s   = rcon(rnd_r - 4'd1);
        end else begin
            sub_in_s = {w3_s[23:0], w3_s[31:24]};
            rcon_s   = rcon(rnd_r);
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_key_sbox
        aes_sbox u_sbox (.a(sub_in_s[8*i +: 8]), .s(sub_out_s[8*i +: 8]));
    end

    assign t_s = sub_out_s ^ {rcon_s, 24'h000000};

    // Forward and inverse key steps share t_s; only one is consumed per state.
    always_comb begin
        logic [31:0] n0, n1, n2;
        n0 = w0_s ^ t_s;
        n1 = w1_s ^ n0;
        n2 = w2_s ^ n1;
        next_key_s = {n0, n1, n2, w3_s ^ n2};
        prev_key_s = {w0_s ^ t_s, w1_s ^ w0_s, w2_s ^ w1_s, w3_s ^ w2_s};
    end

    aes_inv_round u_inv_round (
        .st_in  (st_r),
        .rk     (prev_key_s),
        .last   (rnd_r == 4'd1),
        .st_out (round_out_s)
    );

    assign cache_hit_s = KEY_CACHE && cache_valid_r && (key == k0_cache_r);
    assign in_ready    = (fsm_r == IDLE);
    assign out_valid   = out_valid_r;
    assign out         = out_r;

    // Main FSM with datapath and cache updates; the cached key data survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r         <= IDLE;
            rnd_r         <= 4'd0;
            st_r          <= 128'h0;
            rk_r          <= 128'h0;
            k0_r          <= 128'h0;
            out_r         <= 128'h0;
            out_valid_r   <= 1'b0;
            cache_valid_r <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid) begin
                        k0_r <= key;
                        if (cache_hit_s) begin
                            st_r  <= state ^ rk10_cache_r;
                            rk_r  <= rk10_cache_r;
                            rnd_r <= 4'(NR);
                            fsm_r <= DECRYPT;
                        end else begin
                            st_r  <= state;
                            rk_r  <= key;
                            rnd_r <= 4'd0;
                            fsm_r <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    rk_r  <= next_key_s;
                    rnd_r <= rnd_r + 4'd1;
                    if (rnd_r == 4'(NR - 1)) begin
                        st_r          <= st_r ^ next_key_s;
                        k0_cache_r    <= k0_r;
                        rk10_cache_r  <= next_key_s;
                        cache_valid_r <= 1'b1;
                        fsm_r         <= DECRYPT;
                    end
                end
                DECRYPT: begin
                    st_r  <= round_out_s;
                    rk_r  <= prev_key_s;
                    rnd_r <= rnd_r - 4'd1;
                    if (rnd_r == 4'd1) begin
                        out_r       <= round_out_s;
                        out_valid_r <= 1'b1;
                        fsm_r       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        fsm_r       <= IDLE;
                    end
                end
                default: fsm_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Directed bench for aes_128_dec_iter: known-answer vectors, key-cache latency,
// output backpressure and mid-operation reset.
module tb_aes_128_dec_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] T1_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] T1_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] T1_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] T2_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] T2_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] T2_PT = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_128_dec_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state     (state),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one block and wait for its result with out_ready held low.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] k,
                             input logic [127:0] pt, input int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        state    = ct;
        key      = k;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd1);
        chk({tag, "_latency"}, 128'(n), 128'(lat));
        chk({tag, "_out"}, out, pt);
    endtask

    task automatic release_out(input string tag, input logic [127:0] pt);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_rel_ready"}, 128'(in_ready), 128'd1);
        chk({tag, "_rel_out"}, out, pt);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_out"}, out, 128'd0);
        chk({tag, "_ready"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state     = 128'h0;
        key       = 128'h0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        run_block("t1", T1_CT, T1_K, T1_PT, 20);
        release_out("t1", T1_PT);
        run_block("t2", T2_CT, T2_K, T2_PT, 20);
        release_out("t2", T2_PT);

        run_block("t3a", 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 128'h0, 20);
        release_out("t3a", 128'h0);
        run_block("t3b_hit", 128'h58e2fccefa7e3061367f1d57a4e7455a, 128'h0, 128'h1, 10);
        release_out("t3b", 128'h1);
        run_block("t3c_miss", 128'h0545aad56da2a97c3663d1432a3d1c84, 128'h1, 128'h0, 20);
        release_out("t3c", 128'h0);

        // Backpressure: output held, new requests ignored.
        run_block("t4", T2_CT, T2_K, T2_PT, 20);
        for (int i = 0; i < 7; i++) begin
            in_valid = i[0];
            state    = T1_CT;
            key      = T1_K;
            tick();
            chk("t4_hold_valid", 128'(out_valid), 128'd1);
            chk("t4_hold_out", out, T2_PT);
            chk("t4_hold_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        release_out("t4", T2_PT);
        tick();
        chk("t4_no_accept", 128'(in_ready), 128'd1);

        // Reset during expansion, on the fifth expand edge.
        state    = T1_CT;
        key      = T1_K;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("t5_exp");
        for (int i = 0; i < 25; i++) tick();
        chk("t5_exp_quiet", 128'(out_valid), 128'd0);

        // Reset during decryption; rk10 of T1 was cached just before.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("t5_dec");
        for (int i = 0; i < 12; i++) tick();
        chk("t5_dec_quiet", 128'(out_valid), 128'd0);

        run_block("t5_rerun", T1_CT, T1_K, T1_PT, 20);
        release_out("t5_rerun", T1_PT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
